fp_int2float_pipe: RTL and testbench

Parametrised, pipelined successor of the single-cycle integer-to-DLFloat16 converter. It converts a signed or unsigned INT_W-bit integer to DLFloat16 (1 sign, 6 exponent with bias 31, 9 fraction, no subnormals). Conversion uses round-to-nearest-even and saturates on overflow. A three-stage valid/ready pipeline accepts one conversion per cycle and sits between the integer datapath and the FPU result bus.

---
 rtl/dlf16_pkg.sv | 18 +
 rtl/fp_lzc.sv | 24 ++
 rtl/fp_int2float_pipe.sv | 189 ++++++++++++++++++
 tb/tb_fp_int2float_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlf16_pkg.sv
// DLFloat16 format constants and field layout shared by the int-to-float converter.
package dlf16_pkg;

  localparam int unsigned DLF_EXP_W  = 6;
  localparam int unsigned DLF_FRAC_W = 9;
  localparam int unsigned DLF_BIAS   = 31;

  // Largest finite magnitude; exp=63/frac=1FF is reserved for NaN/Inf.
  localparam logic [14:0] DLF_MAX_FINITE = 15'h7FFE;
  localparam logic [15:0] DLF_ZERO       = 16'h0000;

  typedef struct packed {
    logic                  sign;
    logic [DLF_EXP_W-1:0]  exp;
    logic [DLF_FRAC_W-1:0] frac;
  } dlf16_t;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter. count = W when the input is all zeros.
module fp_lzc #(
  parameter int unsigned W    = 32,
  parameter int unsigned CntW = $clog2(W + 1)
) (
  input  logic [W-1:0]    data,
  output logic [CntW-1:0] count,
  output logic            all_zero
);

  // Scan upward so the highest set bit decides the count.
  always_comb begin
    count = CntW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) begin
        count = CntW'(W - 1 - i);
      end
    end
  end

  // Zero detect, independent of the scan.
  assign all_zero = ~|data;

endmodule

// File: rtl/fp_int2float_pipe.sv
// Pipelined integer to DLFloat16 converter: capture -> normalise -> round/pack.
// Round-to-nearest-even, saturating to max finite on overflow.
// Optional feature: define FP_I2F_FLAGS_EN to add out_flags = {overflow, inexact}.
module fp_int2float_pipe
  import dlf16_pkg::*;
#(
  parameter int unsigned INT_W   = 32,
  parameter int unsigned PIPE_S2 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_int,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_float
`ifdef FP_I2F_FLAGS_EN
  ,
  output logic [1:0]       out_flags
`endif
);

  localparam int unsigned LzW  = $clog2(INT_W + 1);
  localparam int unsigned ExtW = INT_W + 10;

  logic s1_ready, s2_ready, s3_ready;

  // ---------------- S1: capture sign and magnitude ----------------
  logic             s1_valid_q, s1_sign_q;
  logic [INT_W-1:0] s1_mag_q;
  logic             in_sign;

  assign in_sign  = in_signed & in_int[INT_W-1];
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign in_ready = s1_ready;

  // S1 register; most-negative input wraps to 2^(INT_W-1) as an unsigned magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_mag_q  <= in_sign ? (~in_int + INT_W'(1)) : in_int;
      end
    end
  end

  // ---------------- S2: normalise ----------------
  logic [LzW-1:0]   s2_lz;
  logic             s2_zero_d;
  logic [INT_W-1:0] s2_norm_d;
  logic [7:0]       s2_exp_d;

  fp_lzc #(
    .W    (INT_W),
    .CntW (LzW)
  ) u_lzc (
    .data     (s1_mag_q),
    .count    (s2_lz),
    .all_zero (s2_zero_d)
  );

  assign s2_norm_d = s1_mag_q << s2_lz;
  assign s2_exp_d  = 8'(INT_W - 1) - 8'(s2_lz);

  // Inputs to the round stage, either registered or straight from S2 logic.
  logic             s3_in_valid, s3_in_sign, s3_in_zero;
  logic [7:0]       s3_in_exp;
  logic [INT_W-1:0] s3_in_norm;

  if (PIPE_S2 != 0) begin : g_s2_reg
    logic             valid_q, sign_q, zero_q;
    logic [7:0]       exp_q;
    logic [INT_W-1:0] norm_q;

    assign s2_ready = ~valid_q | s3_ready;

    // S2 register between normalise and round.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        sign_q  <= 1'b0;
        zero_q  <= 1'b0;
        exp_q   <= '0;
        norm_q  <= '0;
      end else if (s2_ready) begin
        valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sign_q <= s1_sign_q;
          zero_q <= s2_zero_d;
          exp_q  <= s2_exp_d;
          norm_q <= s2_norm_d;
        end
      end
    end

    assign s3_in_valid = valid_q;
    assign s3_in_sign  = sign_q;
    assign s3_in_zero  = zero_q;
    assign s3_in_exp   = exp_q;
    assign s3_in_norm  = norm_q;
  end else begin : g_s2_comb
    assign s2_ready    = s3_ready;
    assign s3_in_valid = s1_valid_q;
    assign s3_in_sign  = s1_sign_q;
    assign s3_in_zero  = s2_zero_d;
    assign s3_in_exp   = s2_exp_d;
    assign s3_in_norm  = s2_norm_d;
  end

  // ---------------- S3: round and pack ----------------
  logic [ExtW-1:0] ext;
  logic [8:0]      frac_raw, frac_rnd;
  logic [9:0]      frac_sum;
  logic            guard, sticky, round_up, overflow;
  logic [7:0]      exp_b;
  dlf16_t          res;
  logic            unused_lead_one;

  // Zero-padding below the operand covers narrow INT_W without special cases.
  assign ext             = {s3_in_norm, 10'b0};
  assign unused_lead_one = ext[ExtW-1];

  // Round-to-nearest-even, carry into exponent, saturate on overflow.
  always_comb begin
    frac_raw = ext[INT_W+8 -: 9];
    guard    = ext[INT_W-1];
    sticky   = |ext[INT_W-2:0];
    round_up = guard & (sticky | frac_raw[0]);
    frac_sum = {1'b0, frac_raw} + 10'(round_up);
    frac_rnd = frac_sum[8:0];
    exp_b    = s3_in_exp + 8'(DLF_BIAS) + 8'(frac_sum[9]);
    overflow = ~s3_in_zero &
               ((exp_b > 8'd63) || ((exp_b == 8'd63) && (frac_rnd == 9'h1FF)));
    res      = DLF_ZERO;
    if (s3_in_zero) begin
      res = DLF_ZERO;
    end else if (overflow) begin
      res = {s3_in_sign, DLF_MAX_FINITE};
    end else begin
      res = {s3_in_sign, exp_b[5:0], frac_rnd};
    end
  end

  logic        s3_valid_q;
  logic [15:0] s3_float_q;

  assign s3_ready = ~s3_valid_q | out_ready;

`ifdef FP_I2F_FLAGS_EN
  logic       inexact;
  logic [1:0] s3_flags_q;

  assign inexact   = ~s3_in_zero & (guard | sticky | overflow);
  assign out_flags = s3_flags_q;

  // Flags travel with the result word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_flags_q <= 2'b00;
    end else if (s3_ready && s3_in_valid) begin
      s3_flags_q <= {overflow, inexact};
    end
  end
`endif

  // Output register; data holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_float_q <= DLF_ZERO;
    end else if (s3_ready) begin
      s3_valid_q <= s3_in_valid;
      if (s3_in_valid) begin
        s3_float_q <= res;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_float = s3_float_q;

endmodule

// File: tb/tb_fp_int2float_pipe.sv
// Directed bench for fp_int2float_pipe: 32-bit (3-stage), 64-bit overflow, 8-bit 2-stage.
module tb_fp_int2float_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic [31:0] a_in_int;
  logic [15:0] a_out_float;
  // 64-bit instance
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [63:0] b_in_int;
  logic [15:0] b_out_float;
  // 8-bit instance without the S2 register
  logic        c_in_valid, c_in_ready, c_in_signed, c_out_valid, c_out_ready;
  logic [7:0]  c_in_int;
  logic [15:0] c_out_float;
`ifdef FP_I2F_FLAGS_EN
  logic [1:0]  a_out_flags, b_out_flags, c_out_flags;
`endif

  fp_int2float_pipe #(.INT_W(32), .PIPE_S2(1)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_int(a_in_int),
    .in_signed(a_in_signed), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_float(a_out_float)
`ifdef FP_I2F_FLAGS_EN
    , .out_flags(a_out_flags)
`endif
  );

  fp_int2float_pipe #(.INT_W(64), .PIPE_S2(1)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_int(b_in_int),
    .in_signed(b_in_signed), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_float(b_out_float)
`ifdef FP_I2F_FLAGS_EN
    , .out_flags(b_out_flags)
`endif
  );

  fp_int2float_pipe #(.INT_W(8), .PIPE_S2(0)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_int(c_in_int),
    .in_signed(c_in_signed), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_float(c_out_float)
`ifdef FP_I2F_FLAGS_EN
    , .out_flags(c_out_flags)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string tag, input logic [31:0] v, input logic s,
                       input logic [15:0] ef, input logic [1:0] efl);
    a_in_valid = 1'b1; a_in_int = v; a_in_signed = s;
    step();
    a_in_valid = 1'b0;
    step();
    chk({tag, "_lat"}, 64'(a_out_valid), 64'd0);
    step();
    chk({tag, "_vld"}, 64'(a_out_valid), 64'd1);
    chk(tag, 64'(a_out_float), 64'(ef));
`ifdef FP_I2F_FLAGS_EN
    chk({tag, "_flg"}, 64'(a_out_flags), 64'(efl));
`endif
    step();
    chk({tag, "_end"}, 64'(a_out_valid), 64'd0);
  endtask

  task automatic run64(input string tag, input logic [63:0] v, input logic s,
                       input logic [15:0] ef, input logic [1:0] efl);
    b_in_valid = 1'b1; b_in_int = v; b_in_signed = s;
    step();
    b_in_valid = 1'b0;
    step();
    step();
    chk({tag, "_vld"}, 64'(b_out_valid), 64'd1);
    chk(tag, 64'(b_out_float), 64'(ef));
`ifdef FP_I2F_FLAGS_EN
    chk({tag, "_flg"}, 64'(b_out_flags), 64'(efl));
`endif
    step();
  endtask

  task automatic run8(input string tag, input logic [7:0] v, input logic s,
                      input logic [15:0] ef, input logic [1:0] efl);
    c_in_valid = 1'b1; c_in_int = v; c_in_signed = s;
    step();
    c_in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(c_out_valid), 64'd0);
    step();
    chk({tag, "_vld"}, 64'(c_out_valid), 64'd1);
    chk(tag, 64'(c_out_float), 64'(ef));
`ifdef FP_I2F_FLAGS_EN
    chk({tag, "_flg"}, 64'(c_out_flags), 64'(efl));
`endif
    step();
  endtask

  logic [15:0] bp_exp [8];
  logic [31:0] rdy_pat;
  int          sent, rcvd;
  logic        stalled, low_seen, fire_in, fire_out;
  logic [15:0] held;

  initial begin
    rst = 1'b0;
    a_in_valid = 1'b0; a_in_int = '0; a_in_signed = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_int = '0; b_in_signed = 1'b0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_int = '0; c_in_signed = 1'b0; c_out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_float", 64'(a_out_float), 64'h0000);
    chk("rst_out_valid64", 64'(b_out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);

    // Back-to-back 1, -1, 1023
    a_in_valid = 1'b1; a_in_signed = 1'b1; a_in_int = 32'd1;
    step();
    a_in_int = 32'hFFFF_FFFF;
    step();
    a_in_int = 32'd1023;
    chk("b2b_lat", 64'(a_out_valid), 64'd0);
    step();
    a_in_valid = 1'b0;
    chk("b2b_v0", 64'(a_out_valid), 64'd1);
    chk("b2b_one", 64'(a_out_float), 64'h3E00);
    step();
    chk("b2b_v1", 64'(a_out_valid), 64'd1);
    chk("b2b_neg_one", 64'(a_out_float), 64'hBE00);
    step();
    chk("b2b_v2", 64'(a_out_valid), 64'd1);
    chk("b2b_1023", 64'(a_out_float), 64'h51FF);
    step();
    chk("b2b_empty", 64'(a_out_valid), 64'd0);

    // Rounding and boundaries, 32-bit
    run32("tie_even_1025", 32'd1025, 1'b1, 16'h5200, 2'b01);
    run32("round_up_1027", 32'd1027, 1'b1, 16'h5202, 2'b01);
    run32("carry_2047", 32'd2047, 1'b1, 16'h5400, 2'b01);
    run32("most_neg", 32'h8000_0000, 1'b1, 16'hFC00, 2'b00);
    run32("all_ones_uns", 32'hFFFF_FFFF, 1'b0, 16'h7E00, 2'b01);
    run32("zero", 32'd0, 1'b1, 16'h0000, 2'b00);

    // Overflow saturation, 64-bit
    run64("ovf_pos", 64'h0000_0100_0000_0000, 1'b0, 16'h7FFE, 2'b11);
    run64("ovf_neg", 64'hFFFF_FF00_0000_0000, 1'b1, 16'hFFFE, 2'b11);

    // Narrow operand, two-stage pipeline
    run8("w8_127", 8'd127, 1'b1, 16'h4BF8, 2'b00);
    run8("w8_neg128", 8'h80, 1'b1, 16'hCC00, 2'b00);
    run8("w8_255_uns", 8'hFF, 1'b0, 16'h4DFC, 2'b00);

    // Backpressure stream of 1..8
    bp_exp[0] = 16'h3E00; bp_exp[1] = 16'h4000; bp_exp[2] = 16'h4100; bp_exp[3] = 16'h4200;
    bp_exp[4] = 16'h4280; bp_exp[5] = 16'h4300; bp_exp[6] = 16'h4380; bp_exp[7] = 16'h4400;
    rdy_pat  = 32'b1111_1111_1111_1111_1110_0101_1000_1001;
    sent = 0; rcvd = 0; stalled = 1'b0; low_seen = 1'b0; held = '0;
    for (int cyc = 0; cyc < 100 && rcvd < 8; cyc++) begin
      a_out_ready = rdy_pat[cyc % 32];
      a_in_valid  = (sent < 8);
      a_in_int    = 32'(sent + 1);
      a_in_signed = 1'b1;
      #1;
      if (stalled) begin
        chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
        chk("bp_hold_data", 64'(a_out_float), 64'(held));
      end
      chk("bp_in_ready", 64'(a_in_ready), 64'(!((sent - rcvd) == 3 && !a_out_ready)));
      if (!a_in_ready) low_seen = 1'b1;
      fire_in  = a_in_valid & a_in_ready;
      fire_out = a_out_valid & a_out_ready;
      if (fire_out) begin
        chk("bp_data", 64'(a_out_float), 64'(bp_exp[rcvd]));
        rcvd++;
      end
      stalled = a_out_valid & !a_out_ready;
      held    = a_out_float;
      if (fire_in) sent++;
      step();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk("bp_count", 64'(rcvd), 64'd8);
    chk("bp_drained", 64'(a_out_valid), 64'd0);
    chk("bp_in_ready_dropped", 64'(low_seen), 64'd1);

    // Reset with three transactions in flight
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_signed = 1'b1;
    a_in_int = 32'd1; step();
    a_in_int = 32'd2; step();
    a_in_int = 32'd3; step();
    a_in_valid = 1'b0;
    chk("rstmid_full", 64'(a_out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", 64'(a_out_valid), 64'd0);
    chk("rstmid_float", 64'(a_out_float), 64'h0000);
    @(negedge clk);
    rst = 1'b0;
    step();
    a_out_ready = 1'b1;
    chk("rstmid_idle", 64'(a_out_valid), 64'd0);
    run32("rstmid_first", 32'd1027, 1'b1, 16'h5202, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
